// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers for sync_fifo_param. Provides the pointer and
//               count width functions (both derived from ADDR_WIDTH) and the
//               reset values of the status and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Pointers carry one extra wrap bit above the memory address bits, so a
    // full FIFO can be told apart from an empty one.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // The count must represent 0..DEPTH inclusive, which needs the same
    // extra bit as the pointers.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    // Flag values while rst_n is low: an empty FIFO is empty and almost
    // empty, and carries no pending error.
    localparam logic c_rst_full      = 1'b0;
    localparam logic c_rst_empty     = 1'b1;
    localparam logic c_rst_afull     = 1'b0;
    localparam logic c_rst_aempty    = 1'b1;
    localparam logic c_rst_overflow  = 1'b0;
    localparam logic c_rst_underflow = 1'b0;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param_if
// Description : Producer/consumer bundle for sync_fifo_param.
//               master : the user side (drives wr_en/wdata/rd_en/err_clr)
//               slave  : the FIFO side (drives data, status and error flags)
//               Signals: wr_en, wdata, rd_en, err_clr, rdata, rvalid, full,
//               empty, almost_full, almost_empty, count, overflow, underflow.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wdata, rd_en, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface : sync_fifo_param_if
`default_nettype wire

// File: rtl/fifo_mem_dp.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem_dp
// Description : DEPTH x DATA_WIDTH storage for sync_fifo_param.
//               Synchronous write port; read port is registered (rdata is
//               updated on the edge where re is high) unless
//               SYNC_FIFO_FWFT_EN is defined, in which case rdata is a
//               combinational view of mem[raddr].
// Ports       : clk, rst_n (clears only the registered read data),
//               we/waddr/wdata (write), re/raddr/rdata (read).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] waddr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    input  wire logic                  re,
    input  wire logic [ADDR_WIDTH-1:0] raddr,
    output logic      [DATA_WIDTH-1:0] rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    // Storage is deliberately not reset so it can map onto RAM primitives.
    logic [DATA_WIDTH-1:0] mem_q [c_depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through combinationally; the pop strobe and reset have
    // no role on this read port.
    logic w_unused_rd_ctrl;
    assign w_unused_rd_ctrl = re ^ rst_n;
    assign rdata            = mem_q[raddr];
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule : fifo_mem_dp
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parametrised FIFO with registered full/empty,
//               programmable almost-full/almost-empty thresholds, occupancy
//               count and sticky overflow/underflow flags.
//               Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-
//               through output; otherwise reads are registered (data one
//               cycle after the accepted read, qualified by rvalid).
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - sync_fifo_param_if.slave (write, read, status,
//                       error and err_clr signals)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    sync_fifo_param_if.slave  bus
);

    localparam int unsigned      c_ptr_w   = ptr_width(ADDR_WIDTH);
    localparam int unsigned      c_cnt_w   = count_width(ADDR_WIDTH);
    localparam int unsigned      c_depth   = 2 ** ADDR_WIDTH;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(c_depth);
    localparam logic [c_cnt_w-1:0] c_afull     = c_cnt_w'(AFULL_THRESH);
    localparam logic [c_cnt_w-1:0] c_aempty    = c_cnt_w'(AEMPTY_THRESH);

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;
    logic               full_q,   full_d;
    logic               empty_q,  empty_d;
    logic               afull_q,  afull_d;
    logic               aempty_q, aempty_d;
    logic               ovf_q,    ovf_d;
    logic               udf_q,    udf_d;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // ------------------------------------------------------------------
    // Next-state logic. Acceptance only looks at the registered flags, so a
    // simultaneous read never frees room for a write on a full FIFO, and a
    // simultaneous write never supplies data for a read on an empty one.
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_acc = bus.wr_en && !full_q;
        w_rd_acc = bus.rd_en && !empty_q;

        wr_ptr_d = wr_ptr_q + {{(c_ptr_w-1){1'b0}}, w_wr_acc};
        rd_ptr_d = rd_ptr_q + {{(c_ptr_w-1){1'b0}}, w_rd_acc};

        // Modular difference of the wrap-extended pointers is the occupancy.
        count_d  = c_cnt_w'(wr_ptr_d - rd_ptr_d);

        full_d   = (count_d == c_depth_cnt);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= c_afull);
        aempty_d = (count_d <= c_aempty);

        // A fresh error in the same cycle as err_clr wins over the clear.
        ovf_d    = (ovf_q && !bus.err_clr) || (bus.wr_en && full_q);
        udf_d    = (udf_q && !bus.err_clr) || (bus.rd_en && empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= c_rst_full;
            empty_q  <= c_rst_empty;
            afull_q  <= c_rst_afull;
            aempty_q <= c_rst_aempty;
            ovf_q    <= c_rst_overflow;
            udf_q    <= c_rst_underflow;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_acc),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (bus.wdata),
        .re    (w_rd_acc),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (w_mem_rdata)
    );

    // ------------------------------------------------------------------
    // Read-side outputs
    // ------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented whenever data is held; an empty FIFO shows
    // zero rather than stale memory so the output matches its reset value.
    assign bus.rvalid = !empty_q;
    assign bus.rdata  = empty_q ? '0 : w_mem_rdata;
`else
    logic rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= w_rd_acc;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = w_mem_rdata;
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule : sync_fifo_param
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param (8-bit x 16 deep,
//               thresholds 12/4). A queue model holds the expected contents;
//               every cycle the DUT outputs are compared against it.
//               Honours SYNC_FIFO_FWFT_EN for the read-side expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 4;

    logic clk;
    logic rst_n;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb_q [$];
    logic          m_ovf;
    logic          m_udf;
    logic [DW-1:0] exp_rdata;
    logic          exp_rvalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = sb_q.size();
        chk("count",        32'(bus.count),        32'(sz));
        chk("full",         32'(bus.full),         32'(sz == DEPTH));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= AFT));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AET));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_udf));
        chk("rvalid",       32'(bus.rvalid),       32'(exp_rvalid));
        chk("rdata",        32'(bus.rdata),        32'(exp_rdata));
    endtask

    // Refresh read-side expectations for FWFT after the model changed.
    task automatic fwft_expect();
`ifdef SYNC_FIFO_FWFT_EN
        exp_rvalid = (sb_q.size() != 0);
        exp_rdata  = (sb_q.size() != 0) ? sb_q[0] : '0;
`endif
    endtask

    // One clock with the given inputs; model updated from pre-edge state.
    task automatic cyc(input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic ec);
        int  sz;
        bit  acc_w;
        bit  acc_r;
        logic [DW-1:0] popped;
        sz    = sb_q.size();
        acc_w = we && (sz != DEPTH);
        acc_r = re && (sz != 0);
        m_ovf = (m_ovf && !ec) || (we && (sz == DEPTH));
        m_udf = (m_udf && !ec) || (re && (sz == 0));
        if (acc_r) begin
            popped = sb_q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
            exp_rdata = popped;
`endif
        end
        if (acc_w) sb_q.push_back(wd);
`ifndef SYNC_FIFO_FWFT_EN
        exp_rvalid = acc_r;
`endif
        fwft_expect();

        bus.wr_en   = we;
        bus.wdata   = wd;
        bus.rd_en   = re;
        bus.err_clr = ec;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ovf      = 1'b0;
        m_udf      = 1'b0;
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
    endtask

    // Asynchronous reset asserted away from any edge, held for one edge.
    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        bus.wdata   = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        bus.wdata   = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Fill 0x00..0x0F, then an overflowing write of 0xAA.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("ovf_head_read", 32'(bus.rdata), 32'h00);
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to 16, drain all 16, underflow, clear.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_set", 32'(bus.underflow), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Steady state at count 8 with simultaneous read/write, wrapping.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h40 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'h80 + DW'(i), 1'b1, 1'b0);
        chk("steady_count", 32'(bus.count), 32'd8);

        // Simultaneous read/write on an empty FIFO, then on a full one.
        do_reset();
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i < DEPTH; i++) cyc(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b1, 1'b0);
        chk("full_rw_count", 32'(bus.count), 32'd15);
        // Error raised in the same cycle as err_clr stays set.
        cyc(1'b1, 8'h33, 1'b0, 1'b1);
        cyc(1'b1, 8'h44, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of operation discards stored words.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + DW'(i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_count", 32'(bus.count), 32'd0);
        chk("midreset_empty", 32'(bus.empty), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft_rdata",  32'(bus.rdata),  32'h5A);
        chk("fwft_rvalid", 32'(bus.rvalid), 32'h1);
`endif
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_param
`default_nettype wire

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO generalising the team's FIFO to arbitrary data width and power-of-two depth. Adds programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags. Sits between a single-clock producer and consumer, and serves as the synchronous reference model for FIFO verification.

## Interface
- DATA_WIDTH, 8, bits per word
- ADDR_WIDTH, 4, depth = 2**ADDR_WIDTH (DEPTH); minimum 2
- AFULL_THRESH, 12, almost_full asserts when count >= this value; legal range 1..DEPTH
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata qualifier
- full, empty  out  1  registered status flags
- almost_full, almost_empty  out  1  registered threshold flags
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow, underflow  out  1  sticky error flags
- err_clr  in  1  synchronous clear of overflow and underflow

## Operation
- Pointers are ADDR_WIDTH+1 bits: the low bits address memory and the MSB is the wrap bit. Equal pointers mean empty; pointers differing only in the MSB mean full. count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- A write is accepted iff wr_en && !full, and a read iff rd_en && !empty. Both use the registered flags from the current cycle.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- When full, wr_en is rejected even if a read is accepted in the same cycle. Memory is untouched and overflow sets.
- When empty, rd_en is rejected even if a write is accepted in the same cycle. underflow sets and rvalid stays low.
- overflow and underflow hold until err_clr or reset. If err_clr and a new error occur in the same cycle, the flag stays set.
- Flag definitions: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AFULL_THRESH), almost_empty = (count <= AEMPTY_THRESH). All are registered, computed from the next count.
- Reset (asynchronous, rst_n low): pointers, count, rdata, rvalid, full, almost_full, overflow and underflow go to 0; empty and almost_empty go to 1. Memory contents are not reset. Reset mid-operation discards all stored words.

## Timing
- A write accepted at edge k is reflected in count, empty and the almost flags after edge k.
- Standard mode: for a read accepted at edge k, rdata holds the word and rvalid is high for exactly the cycle after edge k. Otherwise rdata holds its last value and rvalid is 0.
- Back-to-back reads give one word per cycle.
- Write-to-read-out minimum latency: 2 edges in standard mode, 1 edge in FWFT mode.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rdata shows the head word whenever !empty, and rvalid = !empty.
  - rd_en acts as a pop acknowledge; the next word appears after the edge.
  - A word written into an empty FIFO is visible after that write edge.
- Undefined: standard registered-read mode as described in Timing.

## Structure
- Package fifo_pkg holds the ptr_t/count_t width helpers (functions of ADDR_WIDTH) and the reset constants for the flags.
- One sub-module, fifo_mem_dp: DEPTH x DATA_WIDTH storage with a synchronous write port and a read port.
  - Read port is registered in standard mode and asynchronous in FWFT mode.
- Pointer, count and flag logic lives in sync_fifo_param.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, AFULL_THRESH=12, AEMPTY_THRESH=4.
- Reset, then check outputs: empty=1, almost_empty=1, count=0, full=0, rvalid=0, overflow=0, underflow=0.
- Write 0x00..0x0F over 16 cycles: full=1 after the 16th edge, almost_full=1 from count=12, almost_empty=0 from count=5. A 17th write (0xAA) sets overflow; a later read returns 0x00, not 0xAA.
- Fill to 16, then read all 16: data returns 0x00..0x0F in order with rvalid high one cycle after each read (standard mode). empty=1 after the last read. One further rd_en sets underflow; err_clr clears it.
- Hold count=8, then assert wr_en and rd_en together for 40 cycles: count stays 8, pointers wrap twice, data order is preserved, and no error flags set.
- With FIFO empty, assert wr_en and rd_en in the same cycle: write accepted (count=1), underflow=1. With FIFO full, same stimulus: read accepted, write rejected, overflow=1, count=15.
- Write 5 words, then assert rst_n low for 1 cycle: count=0 and empty=1 immediately. With SYNC_FIFO_FWFT_EN, a single write of 0x5A shows rdata=0x5A and rvalid=1 after one edge.
